// File: rtl/relay_pkg.sv
// Shared definitions for relay push-button channels: key FSM encoding,
// default timing constants and a counter-width helper.
package relay_pkg;

  typedef enum logic [1:0] {
    K_IDLE  = 2'd0,
    K_PRESS = 2'd1,
    K_LONG  = 2'd2
  } key_state_t;

  // Defaults assume a 50 MHz clk.
  localparam int unsigned DEF_DEB_CYCLES  = 32'd1000000;
  localparam int unsigned DEF_LONG_CYCLES = 32'd100000000;
  localparam int unsigned DEF_HOLD_CYCLES = 32'd25000000;

  // Bits needed to hold values 0..max_val, never less than one.
  function automatic int unsigned cnt_width(input int unsigned max_val);
    int unsigned w;
    w = 1;
    while ((w < 32) && ((max_val >> w) != 0)) w++;
    return w;
  endfunction

endpackage

// File: rtl/key_debounce.sv
// Two-flop synchroniser plus consecutive-sample debouncer for an active-low
// push-button; key_db follows the input only after DEB_CYCLES stable clocks.
module key_debounce
  import relay_pkg::*;
#(
  parameter int unsigned DEB_CYCLES = DEF_DEB_CYCLES
) (
  input  logic CLK,
  input  logic RSTn,
  input  logic BNT,
  output logic key_db
);

  localparam int unsigned   DW       = cnt_width(DEB_CYCLES);
  localparam logic [DW-1:0] DEB_LAST = DW'(DEB_CYCLES - 1);

  logic          sync_1;
  logic          sync_2;
  logic [DW-1:0] deb_cnt;

  // Reset to the released level so a held key is seen as a new press.
  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      sync_1 <= 1'b1;
      sync_2 <= 1'b1;
    end else begin
      sync_1 <= BNT;
      sync_2 <= sync_1;
    end
  end

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      key_db  <= 1'b1;
      deb_cnt <= '0;
    end else if (sync_2 == key_db) begin
      deb_cnt <= '0;
    end else if (deb_cnt == DEB_LAST) begin
      key_db  <= sync_2;
      deb_cnt <= '0;
    end else begin
      deb_cnt <= deb_cnt + DW'(1);
    end
  end

endmodule

// File: rtl/relay_key_ctrl.sv
// Push-button relay controller: short press toggles the relay (subject to a
// dwell time), long press forces the relay off.
//
// state   | meaning
// --------+-----------------------------------------------------------
// K_IDLE  | key released; a debounced press moves to K_PRESS
// K_PRESS | key held, press counter running; release = short press
// K_LONG  | held past LONG_CYCLES; relay forced off, release ignored
module relay_key_ctrl
  import relay_pkg::*;
#(
  parameter int unsigned DEB_CYCLES  = DEF_DEB_CYCLES,
  parameter int unsigned LONG_CYCLES = DEF_LONG_CYCLES,
  parameter int unsigned HOLD_CYCLES = DEF_HOLD_CYCLES
) (
  input  logic CLK,
  input  logic RSTn,
  input  logic BNT,
  output logic RELAY,
  output logic KEY_PRESS,
  output logic BUSY
);

  localparam int unsigned   PW        = cnt_width(LONG_CYCLES);
  localparam int unsigned   HW        = cnt_width(HOLD_CYCLES);
  localparam logic [PW-1:0] PRESS_MAX = PW'(LONG_CYCLES);
  localparam logic [HW-1:0] HOLD_LOAD = HW'(HOLD_CYCLES);

  key_state_t    state;
  key_state_t    state_nxt;
  logic          key_db;
  logic [PW-1:0] press_cnt;
  logic [PW-1:0] press_cnt_nxt;
  logic [HW-1:0] dwell_cnt;
  logic [HW-1:0] dwell_cnt_nxt;
  logic          relay_q;
  logic          relay_nxt;
  logic          short_rel;
  logic          go_long;
  logic          dwell_open;

  key_debounce #(
    .DEB_CYCLES(DEB_CYCLES)
  ) u_key_debounce (
    .CLK   (CLK),
    .RSTn  (RSTn),
    .BNT   (BNT),
    .key_db(key_db)
  );

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      state     <= K_IDLE;
      press_cnt <= '0;
      relay_q   <= 1'b0;
      dwell_cnt <= '0;
    end else begin
      state     <= state_nxt;
      press_cnt <= press_cnt_nxt;
      relay_q   <= relay_nxt;
      dwell_cnt <= dwell_cnt_nxt;
    end
  end

  // key_db cannot fall again within a clock of returning to K_IDLE, so a low
  // key_db seen in K_IDLE is always the clock right after a falling edge.
  always_comb begin
    state_nxt     = state;
    press_cnt_nxt = press_cnt;
    short_rel     = 1'b0;
    go_long       = 1'b0;
    case (state)
      K_IDLE: begin
        press_cnt_nxt = '0;
        if (!key_db) begin
          state_nxt     = K_PRESS;
          press_cnt_nxt = PW'(1);
        end
      end
      K_PRESS: begin
        if (key_db) begin
          short_rel     = 1'b1;
          state_nxt     = K_IDLE;
          press_cnt_nxt = '0;
        end else if (press_cnt == PRESS_MAX) begin
          go_long   = 1'b1;
          state_nxt = K_LONG;
        end else begin
          press_cnt_nxt = press_cnt + PW'(1);
        end
      end
      K_LONG: begin
        if (key_db) begin
          state_nxt     = K_IDLE;
          press_cnt_nxt = '0;
        end
      end
      default: begin
        state_nxt     = K_IDLE;
        press_cnt_nxt = '0;
      end
    endcase
  end

  // A dwell counter of 1 expires on this very clock, so a toggle is allowed.
  assign dwell_open = (dwell_cnt <= HW'(1));

  always_comb begin
    relay_nxt = relay_q;
    if (go_long) begin
      relay_nxt = 1'b0;
    end else if (short_rel && dwell_open) begin
      relay_nxt = ~relay_q;
    end

    if (relay_nxt != relay_q) begin
      dwell_cnt_nxt = HOLD_LOAD;
    end else if (dwell_cnt != '0) begin
      dwell_cnt_nxt = dwell_cnt - HW'(1);
    end else begin
      dwell_cnt_nxt = '0;
    end
  end

  assign RELAY     = relay_q;
  assign BUSY      = (dwell_cnt != '0);
  assign KEY_PRESS = (state == K_IDLE) && !key_db;

endmodule

// File: tb/tb_relay_key_ctrl.sv
// Scoreboard bench for relay_key_ctrl (DEB=4, LONG=20, HOLD=10): stimulus
// queues expected output events by clock number, a monitor pops and compares.
module tb_relay_key_ctrl;

  logic CLK;
  logic RSTn;
  logic BNT;
  logic RELAY;
  logic KEY_PRESS;
  logic BUSY;

  relay_key_ctrl #(
    .DEB_CYCLES (4),
    .LONG_CYCLES(20),
    .HOLD_CYCLES(10)
  ) dut (
    .CLK      (CLK),
    .RSTn     (RSTn),
    .BNT      (BNT),
    .RELAY    (RELAY),
    .KEY_PRESS(KEY_PRESS),
    .BUSY     (BUSY)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  typedef enum int {EV_PRESS = 0, EV_RELAY = 1, EV_BUSY = 2} ev_kind_t;
  typedef struct {
    ev_kind_t kind;
    int       cyc;
    logic     val;
  } ev_t;

  ev_t  exp_q[$];
  int   cyc = 0;
  int   n_checks = 0;
  int   n_pass = 0;
  logic prev_relay = 1'b0;
  logic prev_busy = 1'b0;

  always @(posedge CLK) cyc <= cyc + 1;

  // Keep the queue ordered by clock, then by the order the monitor reports.
  task automatic push(input ev_kind_t k, input int c, input logic v);
    ev_t e;
    int  i;
    e.kind = k;
    e.cyc  = c;
    e.val  = v;
    i = 0;
    while (i < exp_q.size() &&
           (exp_q[i].cyc < c || (exp_q[i].cyc == c && exp_q[i].kind <= k))) i++;
    exp_q.insert(i, e);
  endtask

  task automatic check_ev(input ev_kind_t k, input logic v);
    ev_t e;
    n_checks++;
    if (exp_q.size() == 0) begin
      $display("FAIL unexpected_event: got %s=%0b at cycle %0d, required no event",
               k.name(), v, cyc);
    end else begin
      e = exp_q.pop_front();
      if (e.kind == k && e.cyc == cyc && e.val === v) n_pass++;
      else $display("FAIL event_%s: got %s=%0b at cycle %0d, required %s=%0b at cycle %0d",
                    e.kind.name(), k.name(), v, cyc, e.kind.name(), e.val, e.cyc);
    end
  endtask

  always @(negedge CLK) begin
    if (KEY_PRESS) check_ev(EV_PRESS, 1'b1);
    if (RELAY !== prev_relay) check_ev(EV_RELAY, RELAY);
    if (BUSY !== prev_busy) check_ev(EV_BUSY, BUSY);
    prev_relay <= RELAY;
    prev_busy  <= BUSY;
  end

  // Inputs change 2 ns after a rising edge; the next edge samples them.
  task automatic tick(input int n);
    repeat (n) begin
      @(posedge CLK);
      #2;
    end
  endtask

  initial begin
    int n, m, l, r, q;
    RSTn = 1'b0;
    BNT  = 1'b1;
    tick(3);
    n_checks++;
    if ({RELAY, KEY_PRESS, BUSY} === 3'b000) n_pass++;
    else $display("FAIL reset_state: got RELAY/KEY_PRESS/BUSY=%b, required 000",
                  {RELAY, KEY_PRESS, BUSY});
    RSTn = 1'b1;

    // Idle key: no events at all.
    tick(50);

    // Bounces of 1..3 clocks never pass the debouncer.
    for (int len = 1; len <= 3; len++) begin
      BNT = 1'b0;
      tick(len);
      BNT = 1'b1;
      tick(1);
    end
    tick(10);

    // Short press turns relay on; a second press inside the dwell is dropped.
    n = cyc;
    m = n + 8;
    push(EV_PRESS, n + 6, 1'b1);
    push(EV_RELAY, m + 7, 1'b1);
    push(EV_BUSY, m + 7, 1'b1);
    push(EV_BUSY, m + 17, 1'b0);
    push(EV_PRESS, m + 10, 1'b1);
    BNT = 1'b0; tick(8);
    BNT = 1'b1; tick(4);
    BNT = 1'b0; tick(4);
    BNT = 1'b1; tick(17);

    // Press after the dwell has ended toggles the relay back off.
    n = cyc;
    push(EV_PRESS, n + 6, 1'b1);
    push(EV_RELAY, n + 12, 1'b0);
    push(EV_BUSY, n + 12, 1'b1);
    push(EV_BUSY, n + 22, 1'b0);
    BNT = 1'b0; tick(5);
    BNT = 1'b1; tick(30);

    // Release lands on the clock the dwell expires: toggle accepted.
    n = cyc;
    m = n + 5;
    push(EV_PRESS, n + 6, 1'b1);
    push(EV_RELAY, m + 7, 1'b1);
    push(EV_BUSY, m + 7, 1'b1);
    push(EV_PRESS, m + 10, 1'b1);
    push(EV_RELAY, m + 17, 1'b0);
    push(EV_BUSY, m + 27, 1'b0);
    BNT = 1'b0; tick(5);
    BNT = 1'b1; tick(4);
    BNT = 1'b0; tick(6);
    BNT = 1'b1; tick(30);

    // Relay on, then a 30-clock hold starting inside the dwell forces it off.
    n = cyc;
    m = n + 5;
    l = m + 4;
    push(EV_PRESS, n + 6, 1'b1);
    push(EV_RELAY, m + 7, 1'b1);
    push(EV_BUSY, m + 7, 1'b1);
    push(EV_BUSY, m + 17, 1'b0);
    push(EV_PRESS, l + 6, 1'b1);
    push(EV_RELAY, l + 27, 1'b0);
    push(EV_BUSY, l + 27, 1'b1);
    push(EV_BUSY, l + 37, 1'b0);
    BNT = 1'b0; tick(5);
    BNT = 1'b1; tick(4);
    BNT = 1'b0; tick(30);
    BNT = 1'b1; tick(20);

    // Long press with relay already off changes nothing but KEY_PRESS.
    n = cyc;
    push(EV_PRESS, n + 6, 1'b1);
    BNT = 1'b0; tick(30);
    BNT = 1'b1; tick(15);

    // Reset mid-dwell with key held; press re-registers after a full debounce.
    n = cyc;
    m = n + 5;
    r = m + 12;
    push(EV_PRESS, n + 6, 1'b1);
    push(EV_RELAY, m + 7, 1'b1);
    push(EV_BUSY, m + 7, 1'b1);
    push(EV_PRESS, m + 10, 1'b1);
    push(EV_RELAY, r, 1'b0);
    push(EV_BUSY, r, 1'b0);
    BNT = 1'b0; tick(5);
    BNT = 1'b1; tick(4);
    BNT = 1'b0; tick(r - cyc);
    RSTn = 1'b0;
    q = r + 13;
    push(EV_PRESS, r + 9, 1'b1);
    push(EV_RELAY, q + 7, 1'b1);
    push(EV_BUSY, q + 7, 1'b1);
    push(EV_BUSY, q + 17, 1'b0);
    tick(3);
    RSTn = 1'b1;
    tick(10);
    BNT = 1'b1;
    tick(30);

    tick(10);
    n_checks++;
    if (exp_q.size() == 0) n_pass++;
    else $display("FAIL missing_events: got %0d events never seen (next %s at cycle %0d), required 0",
                  exp_q.size(), exp_q[0].kind.name(), exp_q[0].cyc);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
